// File: rtl/point_pkg.sv
// Shared types and defaults for the point stream between the loader and centroid_calc.
package point_pkg;

  // Default geometry, shared with centroid_calc so both ends agree on depth and width.
  localparam int POINT_WIDTH    = 32;
  localparam int POINT_FRAC     = 16;
  localparam int MAX_POINTS_DEF = 256;

  // One stored sample at the default width (coordinates are opaque signed Qm.FRAC values).
  typedef struct packed {
    logic [POINT_WIDTH-1:0] x;
    logic [POINT_WIDTH-1:0] y;
  } point_t;

  // Replay controller states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } stream_state_t;

endpackage

// File: rtl/point_ram.sv
// Simple dual-port point buffer: one write port, one read port with a registered read.
// The read port samples its address every cycle; the caller steers the address so the
// registered output always holds the word it will need next.
module point_ram #(
  parameter int DW    = 64,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Write port and registered read port; contents deliberately have no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/point_streamer.sv
// Buffers (x,y) points written while idle, then replays them as a valid/ready stream
// framed by a held start level, and waits for the sink's done before finishing.
//
// Handshake: a beat moves on any cycle where valid && ready are both high at the clock
// edge. Once valid is raised, valid, x_out and y_out stay unchanged until that beat is
// accepted; valid never drops between beats of one replay when ready stays high.
//
// Read pipeline: rd_ptr_q is the index of the beat currently on x_out/y_out. The RAM read
// address is always "index of the word needed at the next transfer", so the registered
// RAM output already holds the following point when a beat is accepted. That gives one
// beat per cycle at ready=1 and a two-cycle go-to-first-valid latency.
module point_streamer
  import point_pkg::*;
#(
  parameter int WIDTH      = POINT_WIDTH,
  parameter int FRAC       = POINT_FRAC,
  parameter int MAX_POINTS = MAX_POINTS_DEF,
  localparam int CW        = $clog2(MAX_POINTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_x,
  input  logic [WIDTH-1:0] wr_y,
  input  logic             go,
  input  logic             ready,
  input  logic             sink_done,
  output logic             start,
  output logic             valid,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [CW-1:0]    total_points,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output stream_state_t    dbg_state
);

  localparam logic [CW-1:0] FILL_MAX = CW'(MAX_POINTS - 1);

  // FRAC only documents the coordinate format; nothing here does arithmetic on it.
  logic unused_frac;
  assign unused_frac = (FRAC > 0);

  stream_state_t      state_q;
  logic [CW-1:0]      fill_q;
  logic [CW-1:0]      rd_ptr_q;
  logic [CW-1:0]      total_q;
  logic               start_q;
  logic               valid_q;
  logic               done_q;
  logic               ovf_q;
  logic [2*WIDTH-1:0] out_q;

  logic               in_idle;
  logic               xfer;
  logic               last_beat;
  logic               ram_we;
  logic [CW-1:0]      ram_raddr;
  logic [2*WIDTH-1:0] ram_rdata;
  logic [CW-1:0]      go_fill;

  // Handshake decode and RAM port steering.
  always_comb begin
    in_idle   = (state_q == ST_IDLE);
    xfer      = (state_q == ST_STREAM) && valid_q && ready;
    last_beat = (rd_ptr_q == (total_q - CW'(1)));
    // clear wins over a same-cycle write; writes past the last slot are dropped.
    ram_we    = in_idle && wr_en && !clear && (fill_q < FILL_MAX);
    // go sees the buffer as it stands after a same-cycle clear, before a same-cycle write,
    // so a point written together with go is kept for the next replay, not this one.
    go_fill   = clear ? '0 : fill_q;
    unique case (state_q)
      ST_PREFETCH: ram_raddr = CW'(1);
      ST_STREAM:   ram_raddr = rd_ptr_q + (xfer ? CW'(2) : CW'(1));
      default:     ram_raddr = '0;
    endcase
  end

  point_ram #(
    .DW    (2 * WIDTH),
    .DEPTH (MAX_POINTS),
    .AW    (CW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (fill_q),
    .wdata_i ({wr_x, wr_y}),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Replay FSM with registered outputs, fill/read pointers and the output holding register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      fill_q   <= '0;
      rd_ptr_q <= '0;
      total_q  <= '0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (clear) begin
            fill_q <= '0;
            ovf_q  <= 1'b0;
          end else if (wr_en) begin
            if (fill_q < FILL_MAX) begin
              fill_q <= fill_q + CW'(1);
            end else begin
              ovf_q <= 1'b1;
            end
          end
          if (go) begin
            if (go_fill == '0) begin
              done_q <= 1'b1;
            end else begin
              total_q  <= go_fill;
              rd_ptr_q <= '0;
              state_q  <= ST_PREFETCH;
            end
          end
        end
        ST_PREFETCH: begin
          // RAM output now holds mem[0]; present it and frame the transaction.
          out_q   <= ram_rdata;
          valid_q <= 1'b1;
          start_q <= 1'b1;
          state_q <= ST_STREAM;
        end
        ST_STREAM: begin
          if (xfer) begin
            rd_ptr_q <= rd_ptr_q + CW'(1);
            if (last_beat) begin
              valid_q <= 1'b0;
              state_q <= ST_DRAIN;
            end else begin
              out_q <= ram_rdata;
            end
          end
        end
        ST_DRAIN: begin
          if (sink_done) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          start_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign start        = start_q;
  assign valid        = valid_q;
  assign x_out        = out_q[2*WIDTH-1:WIDTH];
  assign y_out        = out_q[WIDTH-1:0];
  assign total_points = total_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign dbg_state    = state_q;

endmodule
